// File: rtl/rd_stage.sv
// -----------------------------------------------------------------------------
// rd_stage
//
// Register-read pipeline stage. Takes a decoded instruction from ID, reads its
// source operands from the register file (combinational read), and resolves a
// same-cycle writeback to the same register by forwarding the writeback data.
// The result is held in the RD/EX pipeline register that feeds EX and the
// bypass unit. While the held instruction waits for EX, bypass hits for its
// rs1/rs2 are merged into the held operand values every cycle. This means a
// value that retires through WB during a stall is never lost.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   en                  stage enable; 0 freezes all state and blocks handshakes
//   flush               kills the ID offer and the RD/EX contents
//   id_*                instruction offered by ID (valid/ready handshake)
//   rf_raddr*/rf_rdata* register-file read port pair (combinational)
//   wb_*                writeback port, used for write-through on capture
//   byp_*               bypass results for the instruction held in RD/EX
//   ex_*                RD/EX pipeline register contents (valid/ready to EX)
// -----------------------------------------------------------------------------
module rd_stage #(
   parameter  int XLEN      = 32,
   parameter  int NREG      = 32,
   parameter  int PAYLOAD_W = 64,
   localparam int RW        = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 flush,

   // ID side
   input  logic                 id_valid,
   output logic                 id_ready,
   input  logic [RW-1:0]        id_rs1,
   input  logic [RW-1:0]        id_rs2,
   input  logic [RW-1:0]        id_rd,
   input  logic                 id_has_rs1,
   input  logic                 id_has_rs2,
   input  logic                 id_has_rd,
   input  logic [PAYLOAD_W-1:0] id_payload,

   // Register-file read port
   output logic [RW-1:0]        rf_raddr1,
   output logic [RW-1:0]        rf_raddr2,
   input  logic [XLEN-1:0]      rf_rdata1,
   input  logic [XLEN-1:0]      rf_rdata2,

   // Writeback
   input  logic                 wb_we,
   input  logic [RW-1:0]        wb_rd,
   input  logic [XLEN-1:0]      wb_data,

   // Bypass results for the held instruction
   input  logic                 byp_rs1_valid,
   input  logic                 byp_rs2_valid,
   input  logic [XLEN-1:0]      byp_rs1_value,
   input  logic [XLEN-1:0]      byp_rs2_value,

   // RD/EX pipeline register
   output logic                 ex_valid,
   input  logic                 ex_ready,
   output logic [RW-1:0]        ex_rs1,
   output logic [RW-1:0]        ex_rs2,
   output logic [RW-1:0]        ex_rd,
   output logic                 ex_has_rs1,
   output logic                 ex_has_rs2,
   output logic                 ex_has_rd,
   output logic [XLEN-1:0]      ex_rs1_val,
   output logic [XLEN-1:0]      ex_rs2_val,
   output logic [PAYLOAD_W-1:0] ex_payload
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state;

   logic id_fire;
   logic ex_fire;

   logic [XLEN-1:0] cap_rs1_val;
   logic [XLEN-1:0] cap_rs2_val;
   logic [XLEN-1:0] hold_rs1_val;
   logic [XLEN-1:0] hold_rs2_val;

   // --------------------------------------------------------------------------
   // Handshakes
   // --------------------------------------------------------------------------
   // Ready depends on ex_ready so a consumed entry can be replaced in the same
   // cycle (full throughput). Ready is forced low while reset is asserted.
   assign id_ready = en & ~rst & (~ex_valid | ex_ready);
   assign id_fire  = en & id_valid & id_ready & ~flush;
   assign ex_fire  = en & ex_valid & ex_ready;

   // The register-file read is combinational, addressed straight from ID.
   assign rf_raddr1 = id_rs1;
   assign rf_raddr2 = id_rs2;

   // --------------------------------------------------------------------------
   // Operand capture
   // --------------------------------------------------------------------------
   // x0 and unused operands read as zero. A writeback to the same register in
   // the capture cycle has not reached the register file yet, so its data is
   // taken directly and wins over the register-file value.
   function automatic logic [XLEN-1:0] select_operand(
      input logic            has,
      input logic [RW-1:0]   idx,
      input logic [XLEN-1:0] rf_data,
      input logic            we,
      input logic [RW-1:0]   w_idx,
      input logic [XLEN-1:0] w_data
   );
      logic [XLEN-1:0] result;
      if (!has || idx == '0) begin
         result = '0;
      end else if (we && w_idx == idx && w_idx != '0) begin
         result = w_data;
      end else begin
         result = rf_data;
      end
      return result;
   endfunction

   assign cap_rs1_val = select_operand(id_has_rs1, id_rs1, rf_rdata1,
                                       wb_we, wb_rd, wb_data);
   assign cap_rs2_val = select_operand(id_has_rs2, id_rs2, rf_rdata2,
                                       wb_we, wb_rd, wb_data);

   // --------------------------------------------------------------------------
   // Operand refresh while holding
   // --------------------------------------------------------------------------
   // Each operand is refreshed independently from its bypass lane. x0 and
   // unused operands are never overwritten.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves
      // it unassigned and no latch is inferred.
      hold_rs1_val = ex_rs1_val;
      hold_rs2_val = ex_rs2_val;
      if (byp_rs1_valid && ex_has_rs1 && ex_rs1 != '0) begin
         hold_rs1_val = byp_rs1_value;
      end
      if (byp_rs2_valid && ex_has_rs2 && ex_rs2 != '0) begin
         hold_rs2_val = byp_rs2_value;
      end
   end

   // --------------------------------------------------------------------------
   // RD/EX pipeline register and stage FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the whole RD/EX register, payload included, is reset. It is a
         // single pipeline slot rather than a memory array, so clearing it costs
         // nothing and keeps the outputs clean after reset.
         state      <= EMPTY;
         ex_valid   <= 1'b0;
         ex_rs1     <= '0;
         ex_rs2     <= '0;
         ex_rd      <= '0;
         ex_has_rs1 <= 1'b0;
         ex_has_rs2 <= 1'b0;
         ex_has_rd  <= 1'b0;
         ex_rs1_val <= '0;
         ex_rs2_val <= '0;
         ex_payload <= '0;
      end else if (en) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         if (flush) begin
            // The entry is dropped even if EX consumes it in this cycle.
            state    <= EMPTY;
            ex_valid <= 1'b0;
         end else if (id_fire) begin
            // From EMPTY, or from FULL with a same-cycle replace.
            state      <= FULL;
            ex_valid   <= 1'b1;
            ex_rs1     <= id_rs1;
            ex_rs2     <= id_rs2;
            ex_rd      <= id_rd;
            ex_has_rs1 <= id_has_rs1;
            ex_has_rs2 <= id_has_rs2;
            ex_has_rd  <= id_has_rd;
            ex_rs1_val <= cap_rs1_val;
            ex_rs2_val <= cap_rs2_val;
            ex_payload <= id_payload;
         end else if (ex_fire) begin
            state    <= EMPTY;
            ex_valid <= 1'b0;
         end else if (state == FULL) begin
            // Held and waiting for EX: only the operand values change.
            ex_rs1_val <= hold_rs1_val;
            ex_rs2_val <= hold_rs2_val;
         end
      end
   end

endmodule

// File: tb/tb_rd_stage.sv
// -----------------------------------------------------------------------------
// tb_rd_stage
//
// Self-checking bench for rd_stage. A reference model pushes the expected
// RD/EX entry into a queue whenever ID hands over an instruction. It applies
// bypass refreshes to the queued entry while it is held. A separate monitor
// compares the DUT outputs against the head of the queue every cycle and pops
// it when EX consumes it. Directed sequences are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_rd_stage;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int PW   = 64;
   localparam int RW   = $clog2(NREG);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            en, flush;
   logic            id_valid, id_ready;
   logic [RW-1:0]   id_rs1, id_rs2, id_rd;
   logic            id_has_rs1, id_has_rs2, id_has_rd;
   logic [PW-1:0]   id_payload;
   logic [RW-1:0]   rf_raddr1, rf_raddr2;
   logic [XLEN-1:0] rf_rdata1, rf_rdata2;
   logic            wb_we;
   logic [RW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            byp_rs1_valid, byp_rs2_valid;
   logic [XLEN-1:0] byp_rs1_value, byp_rs2_value;
   logic            ex_valid, ex_ready;
   logic [RW-1:0]   ex_rs1, ex_rs2, ex_rd;
   logic            ex_has_rs1, ex_has_rs2, ex_has_rd;
   logic [XLEN-1:0] ex_rs1_val, ex_rs2_val;
   logic [PW-1:0]   ex_payload;

   logic [XLEN-1:0] rf_mem [NREG];

   assign rf_rdata1 = rf_mem[rf_raddr1];
   assign rf_rdata2 = rf_mem[rf_raddr2];

   always #5 clk = ~clk;

   rd_stage #(.XLEN(XLEN), .NREG(NREG), .PAYLOAD_W(PW)) dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_has_rs1(id_has_rs1), .id_has_rs2(id_has_rs2), .id_has_rd(id_has_rd),
      .id_payload(id_payload),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .byp_rs1_valid(byp_rs1_valid), .byp_rs2_valid(byp_rs2_valid),
      .byp_rs1_value(byp_rs1_value), .byp_rs2_value(byp_rs2_value),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_has_rs1(ex_has_rs1), .ex_has_rs2(ex_has_rs2), .ex_has_rd(ex_has_rd),
      .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
      .ex_payload(ex_payload)
   );

   // --------------------------------------------------------------------------
   // Bookkeeping
   // --------------------------------------------------------------------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // --------------------------------------------------------------------------
   // Reference model
   // --------------------------------------------------------------------------
   typedef struct {
      logic [RW-1:0]   rs1, rs2, rd;
      logic            h1, h2, hd;
      logic [XLEN-1:0] v1, v2;
      logic [PW-1:0]   pl;
   } entry_t;

   entry_t exp_q[$];
   entry_t cur;

   // Operand as the instruction should see it at capture time.
   function automatic logic [XLEN-1:0] model_operand(input logic has,
                                                     input logic [RW-1:0] idx);
      if (!has || idx == 0) return '0;
      if (wb_we && wb_rd == idx) return wb_data;
      return rf_mem[idx];
   endfunction

   // The model updates on the clock edge using the inputs held stable since
   // the previous edge. The monitor has already popped an entry that EX takes.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
      end else if (en) begin
         if (flush) begin
            exp_q.delete();
         end else if (id_valid && exp_q.size() == 0) begin
            cur.rs1 = id_rs1;  cur.rs2 = id_rs2;  cur.rd = id_rd;
            cur.h1  = id_has_rs1; cur.h2 = id_has_rs2; cur.hd = id_has_rd;
            cur.v1  = model_operand(id_has_rs1, id_rs1);
            cur.v2  = model_operand(id_has_rs2, id_rs2);
            cur.pl  = id_payload;
            exp_q.push_back(cur);
         end else if (exp_q.size() != 0) begin
            cur = exp_q[0];
            if (byp_rs1_valid && cur.h1 && cur.rs1 != 0) cur.v1 = byp_rs1_value;
            if (byp_rs2_valid && cur.h2 && cur.rs2 != 0) cur.v2 = byp_rs2_value;
            exp_q[0] = cur;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Monitor: mid-cycle comparison against the head of the scoreboard
   // --------------------------------------------------------------------------
   always @(negedge clk) begin
      if (!rst) begin
         check("ex_valid", 64'(ex_valid), 64'(exp_q.size() != 0));
         check("id_ready", 64'(id_ready),
               64'(en && (exp_q.size() == 0 || ex_ready)));
         if (exp_q.size() != 0) begin
            check("ex_rs1",     64'(ex_rs1),     64'(exp_q[0].rs1));
            check("ex_rs2",     64'(ex_rs2),     64'(exp_q[0].rs2));
            check("ex_rd",      64'(ex_rd),      64'(exp_q[0].rd));
            check("ex_has",     64'({ex_has_rs1, ex_has_rs2, ex_has_rd}),
                  64'({exp_q[0].h1, exp_q[0].h2, exp_q[0].hd}));
            check("ex_rs1_val", 64'(ex_rs1_val), 64'(exp_q[0].v1));
            check("ex_rs2_val", 64'(ex_rs2_val), 64'(exp_q[0].v2));
            check("ex_payload", ex_payload,      exp_q[0].pl);
            if (en && ex_ready) exp_q.pop_front();
         end
      end
   end

   // --------------------------------------------------------------------------
   // Stimulus helpers
   // --------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      en = 1'b1;  flush = 1'b0;  id_valid = 1'b0;  ex_ready = 1'b1;
      wb_we = 1'b0;  wb_rd = '0;  wb_data = '0;
      byp_rs1_valid = 1'b0;  byp_rs2_valid = 1'b0;
      byp_rs1_value = '0;  byp_rs2_value = '0;
   endtask

   task automatic set_instr(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                            input logic h1, input logic h2);
      id_valid   = 1'b1;
      id_rs1     = rs1;
      id_rs2     = rs2;
      id_rd      = RW'($urandom);
      id_has_rs1 = h1;
      id_has_rs2 = h2;
      id_has_rd  = 1'($urandom);
      id_payload = {$urandom, $urandom};
   endtask

   // --------------------------------------------------------------------------
   // Test sequence
   // --------------------------------------------------------------------------
   initial begin
      for (int i = 0; i < NREG; i++) rf_mem[i] = $urandom | 32'h1;
      rf_mem[7] = 32'h0000_5555;
      drive_idle();
      set_instr('0, '0, 1'b0, 1'b0);
      id_valid = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset ex_valid",   64'(ex_valid),   64'd0);
      check("reset ex_rs1_val", 64'(ex_rs1_val), 64'd0);
      check("reset ex_payload", ex_payload,      64'd0);
      check("reset id_ready",   64'(id_ready),   64'd0);
      rst = 1'b0;
      step();

      // Stream of four with EX always ready: one per cycle, ready stays high
      for (int i = 0; i < 4; i++) begin
         set_instr(RW'(i + 1), RW'(i + 10), 1'b1, 1'b1);
         #1;
         check("stream id_ready", 64'(id_ready), 64'd1);
         step();
      end
      drive_idle();
      step();

      // Write-through on capture, and x0 ignores a writeback to register 0
      rf_mem[5] = 32'h11;
      set_instr(5'd5, 5'd6, 1'b1, 1'b1);
      wb_we = 1'b1;  wb_rd = 5'd5;  wb_data = 32'hAA;
      step();
      check("wt ex_rs1_val", 64'(ex_rs1_val), 64'h0000_00AA);
      set_instr(5'd0, 5'd6, 1'b1, 1'b1);
      wb_rd = 5'd0;  wb_data = 32'hBB;
      step();
      check("x0 ex_rs1_val", 64'(ex_rs1_val), 64'd0);

      // Hold for three cycles with a bypass hit on rs2 in the second one
      drive_idle();
      set_instr(5'd3, 5'd7, 1'b1, 1'b1);
      step();
      ex_ready = 1'b0;
      set_instr(5'd8, 5'd9, 1'b1, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         byp_rs2_valid = (c == 2);
         byp_rs2_value = 32'h1234;
         #1;
         check("hold id_ready", 64'(id_ready), 64'd0);
         step();
         if (c >= 2) check("hold ex_rs2_val", 64'(ex_rs2_val), 64'h1234);
         check("hold ex_rs1_val", 64'(ex_rs1_val), 64'(rf_mem[3]));
      end
      byp_rs2_valid = 1'b0;

      // Flush with ID offering and RD/EX full: entry dropped, offer ignored
      flush = 1'b1;
      step();
      check("flush ex_valid", 64'(ex_valid), 64'd0);
      drive_idle();
      step();
      check("flush no capture", 64'(ex_valid), 64'd0);

      // Enable low: no handshake, state frozen
      set_instr(5'd4, 5'd2, 1'b1, 1'b1);
      step();
      en = 1'b0;  ex_ready = 1'b1;
      set_instr(5'd11, 5'd12, 1'b1, 1'b1);
      #1;
      check("en0 id_ready", 64'(id_ready), 64'd0);
      step();
      check("en0 ex_valid", 64'(ex_valid), 64'd1);
      step();
      drive_idle();
      step();

      // Reset pulsed between edges while FULL
      set_instr(5'd9, 5'd10, 1'b1, 1'b1);
      step();
      drive_idle();
      ex_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst ex_valid",   64'(ex_valid),   64'd0);
      check("midrst ex_rs1_val", 64'(ex_rs1_val), 64'd0);
      check("midrst id_ready",   64'(id_ready),   64'd0);
      #1;
      rst = 1'b0;
      step();

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         set_instr(($urandom_range(0, 7) == 0) ? '0 : RW'($urandom),
                   ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom),
                   1'($urandom), 1'($urandom));
         id_valid      = ($urandom_range(0, 3) != 0);
         en            = ($urandom_range(0, 9) != 0);
         flush         = ($urandom_range(0, 19) == 0);
         ex_ready      = ($urandom_range(0, 9) < 6);
         wb_we         = 1'($urandom);
         wb_rd         = 1'($urandom) ? id_rs1 : (1'($urandom) ? id_rs2 : RW'($urandom));
         wb_data       = $urandom;
         byp_rs1_valid = ($urandom_range(0, 2) == 0);
         byp_rs2_valid = ($urandom_range(0, 2) == 0);
         byp_rs1_value = $urandom;
         byp_rs2_value = $urandom;
         step();
      end

      drive_idle();
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/rd_stage.md
Name: rd_stage

Overview:
- Register-read stage. Accepts decoded instructions from ID, reads the register file, and resolves a same-cycle writeback collision.
- Holds the result in the RD/EX pipeline register that feeds EX and the bypass unit.
- While an instruction sits in RD/EX waiting for EX, the bypass unit's rs1/rs2 results are merged into the held operands every cycle. A value that passes through WB during a stall is therefore never lost.

Parameters:
- XLEN, 32, register/operand width.
- NREG, 32, architectural register count (index width = $clog2(NREG)).
- PAYLOAD_W, 64, opaque decoded-instruction payload carried to EX unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  stage enable; when 0, all state holds and no handshakes complete.
- flush  in  1  kill ID input and RD/EX contents (branch redirect).
- id_valid  in  1  ID offers an instruction.
- id_ready  out  1  stage can accept this cycle.
- id_rs1, id_rs2, id_rd  in  $clog2(NREG) each  register indices.
- id_has_rs1, id_has_rs2, id_has_rd  in  1 each  operand/dest usage.
- id_payload  in  PAYLOAD_W  decoded fields.
- rf_raddr1, rf_raddr2  out  $clog2(NREG)  register-file read addresses (combinational = id_rs1/id_rs2).
- rf_rdata1, rf_rdata2  in  XLEN  combinational register-file read data.
- wb_we  in  1  writeback this cycle.
- wb_rd  in  $clog2(NREG)  writeback register index.
- wb_data  in  XLEN  writeback data.
- byp_rs1_valid, byp_rs2_valid  in  1  bypass hit for the held RD/EX instruction.
- byp_rs1_value, byp_rs2_value  in  XLEN  bypass data.
- ex_valid  out  1  RD/EX holds a live instruction.
- ex_ready  in  1  EX consumes RD/EX this cycle.
- ex_rs1, ex_rs2, ex_rd  out  $clog2(NREG)  held indices.
- ex_has_rs1, ex_has_rs2, ex_has_rd  out  1 each  held usage flags.
- ex_rs1_val, ex_rs2_val  out  XLEN  held operand values.
- ex_payload  out  PAYLOAD_W  held payload.

Behaviour:
- Reset (async):
  - ex_valid=0.
  - All ex_* index, flag, value and payload registers = 0.
  - State = EMPTY.
  - Reset may assert in any state, mid-handshake included; the transfer in progress is discarded.
- Handshakes:
  - id_fire = en & id_valid & id_ready & !flush.
  - ex_fire = en & ex_valid & ex_ready.
  - id_ready = en & !rst & (!ex_valid | ex_ready). Same-cycle replace is allowed, giving full throughput.
- States:
  - EMPTY (ex_valid=0):
    - id_fire -> FULL.
  - FULL (ex_valid=1):
    - ex_fire & !id_fire -> EMPTY.
    - ex_fire & id_fire -> FULL with the new instruction.
    - !ex_fire -> FULL, holding the instruction and refreshing its operands.
  - flush (when en=1):
    - Next state = EMPTY and ex_valid=0 next cycle, regardless of id_valid or ex_ready.
    - Whether the EX consumption in the flush cycle counts is EX's concern; this stage still drops the entry.
- Capture on id_fire (operand x in {1,2}):
  - If has_rsx=0 or rsx==0: value 0.
  - Else if wb_we & wb_rd==rsx & wb_rd!=0: wb_data (write-through; wins over rf_rdata).
  - Else: rf_rdatax.
- Refresh while holding (FULL & !ex_fire & en & !flush), per operand independently:
  - If byp_rsx_valid & ex_has_rsx & ex_rsx!=0: ex_rsx_val <= byp_rsx_value.
  - Indices, flags and payload do not change.
- en=0: no state change; id_ready=0; outputs hold their values.
- Latency: 1 cycle from ID to ex_valid; combinational register-file read.
- x0: always reads 0, and is never overwritten by bypass or writeback.

Test Plan:
1. Reset mid-FULL (ex_valid=1, rst pulsed between edges) -> ex_valid=0 and ex_rs1_val=0 immediately; id_ready=0 while rst=1.
2. Stream 4 instructions with ex_ready=1 throughout -> one accepted per cycle; ex_rs1_val equals rf_rdata1 from the cycle before; id_ready stays 1.
3. Capture rs1=5 with rf_rdata1=0x11 while wb_we=1, wb_rd=5, wb_data=0xAA -> ex_rs1_val=0xAA. Repeat with rs1=0 and wb_rd=0 -> 0.
4. Hold: ex_ready=0 for 3 cycles; byp_rs2_valid=1 with value 0x1234 in cycle 2 only -> ex_rs2_val=0x1234 from cycle 3 onward; ex_rs1_val unchanged; id_ready=0 throughout.
5. flush with id_valid=1 and ex_valid=1 -> next cycle ex_valid=0; the ID instruction is not captured.
6. en=0 with id_valid=1 and ex_ready=1 -> id_ready=0, all ex_* registers unchanged.
